sparc_ifu_thrsched: RTL
=======================

Name: sparc_ifu_thrsched

Overview:
- Thread scheduler for the 4-thread IFU switch logic.
- Consumes the registered 5-bit state of the four per-thread FSMs.
- Produces the per-thread schedule pulses and the common switch_out that drive those FSMs' RDY/SPEC_RDY->RUN and RUN->RDY transitions.
- Picks the next thread round-robin, prefers RDY threads over SPEC_RDY threads, and enforces a run quantum.

Parameters:
- QUANTUM, 16: cycles a thread may run before a forced switch_out when another RDY thread waits; legal range 2..2^CNT_W.
- CNT_W, 4: quantum counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- thr0_state  in  5  registered state of thread 0 FSM
- thr1_state  in  5  registered state of thread 1 FSM
- thr2_state  in  5  registered state of thread 2 FSM
- thr3_state  in  5  registered state of thread 3 FSM
- thr_stall  in  4  per-thread stall (same signals as the FSM stall inputs)
- sw_cond  in  1  running thread must switch and wait
- fcl_hold  in  1  fetch pipe frozen; no switch this cycle
- spec_en  in  1  allow scheduling of SPEC_RDY threads
- schedule  out  4  one-hot per-thread switch-in pulse
- switch_out  out  1  quantum switch-out of the running thread
- run_thr  out  4  one-hot running thread, combinational from states
- last_thr  out  2  last scheduled thread (registered)
- err_multi_run  out  1  sticky: more than one thread in RUN/SPEC_RUN

Behaviour:
- State codes: IDLE 00000, HALT 00010, WAIT 00001, RDY 11001, RUN 00101, SPEC_RDY 10011, SPEC_RUN 00111.
- running[i] = state is RUN or SPEC_RUN (exact decode).
- Any other code is never a candidate and never counts as running.
- rdy[i] = state==RDY.
- spc[i] = state==SPEC_RDY & spec_en.
- leaving = running thread has thr_stall or sw_cond asserted.
- q_exp = running & cnt==QUANTUM-1.
- switch_out = running & q_exp & |rdy & ~leaving & ~fcl_hold & ~err_cond. spc-only candidates never force a switch_out.
- sched_en = ~fcl_hold & ~err_cond & (~|running | leaving | switch_out).
- Pick set = rdy if |rdy, else spc.
- Round-robin search order: last_thr+1, +2, +3, +4, mod 4. The first set bit wins.
- schedule = sched_en ? onehot(pick) : 0.
- If the pick set is empty, schedule=0 and switch_out=0.
- Decision is combinational from current states and registers (0-cycle). Scheduled thread shows RUN/SPEC_RUN at the next edge. An outgoing thread goes to RDY or WAIT at the same edge (zero-bubble handover).
- A stall on a RDY thread has priority inside its FSM. A schedule issued to it is harmless and still updates last_thr.
- Registers:
  - last_thr <= pick when |schedule.
  - cnt: 0 when |schedule.
  - cnt: cnt+1 when running & cnt<QUANTUM-1 & ~fcl_hold.
  - cnt otherwise holds (saturates).
- err_cond = more than one running bit set.
- err_multi_run sets when err_cond, is cleared only by reset, and suppresses schedule/switch_out while err_cond holds.
- run_thr = running vector (may be multi-hot only when err_cond).
- Reset: last_thr=2'b11 (thread 0 searched first), cnt=0, err_multi_run=0. schedule and switch_out are 0 during reset.
- Reset mid-quantum clears cnt; the first post-reset pick starts at thread 0.
- Simultaneous sw_cond and q_exp: no switch_out; a schedule is still issued via leaving.

Decomposition:
- Package sparc_ifu_thr_pkg: THRFSM_* state constants, NTHR=4, and the decode functions is_running/is_rdy/is_spec_rdy. This package is shared with the thread FSM.
- Sub-module sparc_ifu_rr_pick4: 4-bit request, 2-bit pointer -> one-hot grant plus encoded index. Purely combinational.

Test Plan:
- Reset; thr0=RDY, others IDLE -> schedule=0001 in the first cycle. thr0 set RUN next cycle -> schedule=0000; last_thr=0.
- thr0=RUN, thr2=RDY, QUANTUM=16, no hold -> switch_out=1 and schedule=0100 together in the 16th run cycle (cnt=15). cnt=0 next cycle.
- last_thr=1, thr1=RUN with sw_cond=1, thr0=RDY, thr3=RDY -> schedule=1000, switch_out=0; last_thr=3 next cycle.
- No thread running, thr2=SPEC_RDY, thr3=RDY -> schedule=1000. Only thr2=SPEC_RDY: spec_en=0 -> schedule=0; spec_en=1 -> schedule=0100.
- thr0=RUN with cnt saturated, thr1=RDY, fcl_hold=1 -> schedule=0, switch_out=0, cnt holds 15. Drop fcl_hold -> switch_out=1 and schedule=0010 that cycle.
- Force thr0 and thr1 = RUN -> err_multi_run=1 (sticky after states are fixed), schedule=0. reset -> err_multi_run=0, cnt=0, last_thr=3.

Source files
------------

// File: rtl/sparc_ifu_thr_pkg.sv
// Thread FSM state encodings and decode helpers shared by the IFU thread
// FSMs and the thread scheduler.
package sparc_ifu_thr_pkg;

    localparam int NTHR = 4;

    localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
    localparam logic [4:0] THRFSM_HALT     = 5'b00010;
    localparam logic [4:0] THRFSM_WAIT     = 5'b00001;
    localparam logic [4:0] THRFSM_RDY      = 5'b11001;
    localparam logic [4:0] THRFSM_RUN      = 5'b00101;
    localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
    localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;

    // Exact decodes: a corrupted code is never a candidate and never running.
    function automatic logic is_running(input logic [4:0] st);
        return (st == THRFSM_RUN) || (st == THRFSM_SPEC_RUN);
    endfunction

    function automatic logic is_rdy(input logic [4:0] st);
        return st == THRFSM_RDY;
    endfunction

    function automatic logic is_spec_rdy(input logic [4:0] st);
        return st == THRFSM_SPEC_RDY;
    endfunction

endpackage

// File: rtl/sparc_ifu_rr_pick4.sv
// Four-way round-robin picker: searches ptr+1 .. ptr+4 (mod 4) and grants
// the first requesting slot. Purely combinational.
module sparc_ifu_rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic [1:0] idx_o
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = ptr_i;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_i + 2'(k);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU thread scheduler: round-robin switch-in of RDY (then SPEC_RDY) threads
// with a run quantum that forces a switch-out when another RDY thread waits.
module sparc_ifu_thrsched
    import sparc_ifu_thr_pkg::*;
#(
    parameter int QUANTUM = 16,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] thr0_state,
    input  logic [4:0] thr1_state,
    input  logic [4:0] thr2_state,
    input  logic [4:0] thr3_state,
    input  logic [3:0] thr_stall,
    input  logic       sw_cond,
    input  logic       fcl_hold,
    input  logic       spec_en,
    output logic [3:0] schedule,
    output logic       switch_out,
    output logic [3:0] run_thr,
    output logic [1:0] last_thr,
    output logic       err_multi_run
);

    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUANTUM - 1);

    logic [4:0]       thr_state [NTHR];
    logic [NTHR-1:0]  running, rdy, spc, pick_req, pick_grant;
    logic [1:0]       pick_idx;
    logic             any_run, err_cond, leaving, q_exp, sw_int, sched_en;

    logic [1:0]       last_thr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign thr_state[0] = thr0_state;
    assign thr_state[1] = thr1_state;
    assign thr_state[2] = thr2_state;
    assign thr_state[3] = thr3_state;

    always_comb begin
        running = '0;
        rdy     = '0;
        spc     = '0;
        for (int i = 0; i < NTHR; i++) begin
            running[i] = is_running(thr_state[i]);
            rdy[i]     = is_rdy(thr_state[i]);
            spc[i]     = is_spec_rdy(thr_state[i]) & spec_en;
        end
    end

    assign any_run  = |running;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign err_cond = |(running & (running - 4'd1));
    assign leaving  = (|(running & thr_stall)) | (any_run & sw_cond);
    assign q_exp    = any_run & (cnt_q == Q_LAST);
    assign sw_int   = q_exp & (|rdy) & ~leaving & ~fcl_hold & ~err_cond;
    assign sched_en = ~fcl_hold & ~err_cond & (~any_run | leaving | sw_int);
    assign pick_req = (|rdy) ? rdy : spc;

    sparc_ifu_rr_pick4 u_pick (
        .req_i   (pick_req),
        .ptr_i   (last_thr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign schedule      = (sched_en & ~reset) ? pick_grant : '0;
    assign switch_out    = sw_int & ~reset;
    assign run_thr       = running;
    assign last_thr      = last_thr_q;
    assign err_multi_run = err_q;

    // Quantum counter saturates at QUANTUM-1 and freezes while the pipe holds.
    always_comb begin
        cnt_d = cnt_q;
        if (|schedule) begin
            cnt_d = '0;
        end else if (any_run && (cnt_q < Q_LAST) && !fcl_hold) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_thr_q <= 2'b11;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (|schedule) begin
                last_thr_q <= pick_idx;
            end
            cnt_q <= cnt_d;
            err_q <= err_q | err_cond;
        end
    end

endmodule
